// File: rtl/nios_system_key_pkg.sv
// Shared constants and types for the pushbutton controller.
// Register map, repeat-state enum and counter sizing helper.
package nios_system_key_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RPT  = 2'd3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/nios_system_key_chan.sv
// One key channel: synchronizer, debounce and auto-repeat FSM.
// key_event is a one-cycle registered pulse per press/repeat.
module nios_system_key_chan
  import nios_system_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic rpt_en,
  output logic pressed,
  output logic key_event
);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

  logic [1:0]    sync;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] timer;
  rpt_state_t    state;
  logic          synced;
  logic          differ;
  logic          commit;

  assign synced = sync[1];
  assign differ = synced != pressed;
  assign commit = differ && (db_cnt == DB_LAST);

  // Inversion happens on entry so a cleared synchronizer means released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], ~key_n};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed <= 1'b0;
      db_cnt  <= '0;
    end else if (!differ) begin
      db_cnt  <= '0;
    end else if (commit) begin
      pressed <= synced;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RPT_IDLE;
      timer     <= '0;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (commit && !synced) begin
        state <= RPT_IDLE;
      end else begin
        unique case (state)
          RPT_IDLE: begin
            if (commit && synced) begin
              key_event <= 1'b1;
              state     <= RPT_DELAY;
              timer     <= RD_LAST;
            end
          end
          RPT_DELAY: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else if (rpt_en) begin
              key_event <= 1'b1;
              state     <= RPT_REPEAT;
              timer     <= RR_LAST;
            end
          end
          RPT_REPEAT: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              key_event <= 1'b1;
              timer     <= RR_LAST;
            end
          end
          default: state <= RPT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/nios_system_key_ctrl.sv
// Avalon-MM pushbutton controller with debounce and auto-repeat.
// Holds the register file and interrupt; channels do the key timing.
module nios_system_key_ctrl
  import nios_system_key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] in_port,
  output logic                irq
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] key_event;
  logic [NUM_KEYS-1:0] irq_mask;
  logic [NUM_KEYS-1:0] edge_cap;
  logic [NUM_KEYS-1:0] rpt_en;
  logic [NUM_KEYS-1:0] wdata;
  logic [NUM_KEYS-1:0] edge_clr;
  logic [31:0]         rd_next;
  logic                wr;
  logic                unused_wdata;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    nios_system_key_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CW             (CW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .key_n    (in_port[k]),
      .rpt_en   (rpt_en[k]),
      .pressed  (pressed[k]),
      .key_event(key_event[k])
    );
  end

  assign wr           = chipselect && !write_n;
  assign wdata        = writedata[NUM_KEYS-1:0];
  assign unused_wdata = ^writedata;
  assign edge_clr     = (wr && address == ADDR_EDGE) ? wdata : '0;

  always_comb begin
    rd_next = '0;
    unique case (address)
      ADDR_DATA: rd_next[NUM_KEYS-1:0] = pressed;
      ADDR_MASK: rd_next[NUM_KEYS-1:0] = irq_mask;
      ADDR_EDGE: rd_next[NUM_KEYS-1:0] = edge_cap;
      ADDR_RPT:  rd_next[NUM_KEYS-1:0] = rpt_en;
    endcase
  end

  // A new event outranks a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      rpt_en   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && address == ADDR_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_RPT)  rpt_en   <= wdata;
      edge_cap <= (edge_cap & ~edge_clr) | key_event;
      readdata <= rd_next;
      irq      <= |(edge_cap & irq_mask);
    end
  end

endmodule
